// File: rtl/xsd_pkg.sv
// Shared types and the decode rule for the XOR/conditional-shift byte decoder.
package xsd_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        NOKEY = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              amb;
        logic              err;
    } entry_t;

    // With key[7]=1 the encoder shifted left, so the top plaintext bit is gone
    // and a set LSB in the encoded byte cannot have come from a valid encode.
    function automatic entry_t decode(input logic [BYTE_W-1:0] key,
                                      input logic [BYTE_W-1:0] enc);
        entry_t e;
        if (key[BYTE_W-1]) begin
            e.data = {1'b0, enc[BYTE_W-1:1] ^ key[BYTE_W-2:0]};
            e.amb  = 1'b1;
            e.err  = enc[0];
        end else begin
            e.data = enc ^ key;
            e.amb  = 1'b0;
            e.err  = 1'b0;
        end
        return e;
    endfunction

endpackage

// File: rtl/xsd_fifo.sv
// Synchronous FIFO of decoded entries; head output holds the last popped entry while empty.
module xsd_fifo
    import xsd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    entry_t      mem [DEPTH];
    entry_t      last_q;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // last_q keeps the most recently delivered entry visible once the FIFO drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/xor_shift_decoder.sv
// Decodes XOR/conditional-shift encoded bytes against a loaded key into a small output FIFO.
// Build option: define XSD_ERR_COUNT_EN to build the saturating format-error counter.
module xor_shift_decoder
    import xsd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [BYTE_W-1:0] key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_amb,
    output logic              out_err,
    output logic              key_valid,
    output logic [CNT_W-1:0]  err_count
);

    // Both streams transfer on a clock edge where valid && ready; a source holds
    // its payload stable while valid=1 and ready=0. in_ready never looks at out_ready.

    state_t            state;
    state_t            state_n;
    logic [BYTE_W-1:0] key_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    entry_t            in_entry;
    entry_t            head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= NOKEY;
            key_q <= '0;
        end else begin
            state <= state_n;
            if (key_load) begin
                key_q <= key_in;
            end
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            NOKEY: begin
                if (key_load) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                in_ready = !fifo_full;
            end
            default: state_n = NOKEY;
        endcase
    end

    assign key_valid = (state == RUN);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_entry  = decode(key_q, in_data);

    xsd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(in_entry),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_amb   = head.amb;
    assign out_err   = head.err;

`ifdef XSD_ERR_COUNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (push && in_entry.err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_xor_shift_decoder.sv
// Directed self-checking bench for xor_shift_decoder (DEPTH=4, CNT_W=8).
module tb_xor_shift_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_load;
    logic [7:0] key_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_amb;
    logic       out_err;
    logic       key_valid;
    logic [7:0] err_count;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_errs = 8'd0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    xor_shift_decoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_load (key_load),
        .key_in   (key_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_amb  (out_amb),
        .out_err  (out_err),
        .key_valid(key_valid),
        .err_count(err_count)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_load = 1'b0; key_in = 8'h00;
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_amb !== 1'b0 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b d=%h a=%b e=%b, expected 0 00 0 0", out_valid, out_data, out_amb, out_err);
        end
        tests_run++;
        if (err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_err_count: got %0d expected 0", err_count);
        end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (in_ready !== 1'b0 || key_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL nokey_idle[%0d]: got in_ready=%b key_valid=%b expected 0 0", i, in_ready, key_valid);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_key_load();
        load_key(8'h3C);
        tests_run++;
        if (key_valid !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL key_load: got key_valid=%b in_ready=%b expected 1 1", key_valid, in_ready);
        end
    endtask

    task automatic test_decode_plain();
        in_valid = 1'b1; in_data = 8'hA5;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL plain_pre_valid: got %b expected 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h99 || out_amb !== 1'b0 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL plain_decode: got v=%b d=%h a=%b e=%b expected 1 99 0 0", out_valid, out_data, out_amb, out_err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'h99) begin
            tests_failed++;
            $display("FAIL empty_hold: got v=%b d=%h expected 0 99", out_valid, out_data);
        end
    endtask

    task automatic test_decode_shift();
        load_key(8'h85);
        in_valid = 1'b1; in_data = 8'h4A;
        tick();
        in_data = 8'h4B;
        tick();
        in_valid = 1'b0;
`ifdef XSD_ERR_COUNT_EN
        exp_errs = exp_errs + 8'd1;
`endif
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h20 || out_amb !== 1'b1 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL shift_4A: got v=%b d=%h a=%b e=%b expected 1 20 1 0", out_valid, out_data, out_amb, out_err);
        end
        tests_run++;
        if (err_count !== exp_errs) begin
            tests_failed++;
            $display("FAIL err_count_4B: got %0d expected %0d", err_count, exp_errs);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h20 || out_amb !== 1'b1 || out_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL shift_4B: got v=%b d=%h a=%b e=%b expected 1 20 1 1", out_valid, out_data, out_amb, out_err);
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL shift_drained: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic       pushed;
        logic [7:0] exp;
        int         guard;
        load_key(8'h00);
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tests_run++;
            if (in_ready !== (i <= 4)) begin
                tests_failed++;
                $display("FAIL fill_in_ready[%0d]: got %b expected %b", i, in_ready, (i <= 4));
            end
            if (i <= 4) begin
                exp_q.push_back(8'(i));
                tick();
            end
        end
        exp_q.push_back(8'h05);
        out_ready = 1'b1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_no_comb_path: got in_ready=%b expected 0", in_ready);
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            if (out_valid === 1'b1) begin
                exp = exp_q.pop_front();
                tests_run++;
                if (out_data !== exp) begin
                    tests_failed++;
                    $display("FAIL drain_order: got %h expected %h", out_data, exp);
                end
            end
            pushed = in_valid && in_ready;
            tick();
            if (pushed) in_valid = 1'b0;
            guard++;
        end
        tests_run++;
        if (exp_q.size() != 0 || guard != 5) begin
            tests_failed++;
            $display("FAIL drain_timing: got %0d left after %0d cycles expected 0 after 5", exp_q.size(), guard);
        end
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_key_switch();
        load_key(8'h00);
        key_load = 1'b1; key_in = 8'h80;
        in_valid = 1'b1; in_data = 8'h10;
        tick();
        key_load = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h10 || out_amb !== 1'b0) begin
            tests_failed++;
            $display("FAIL old_key: got v=%b d=%h a=%b expected 1 10 0", out_valid, out_data, out_amb);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h08 || out_amb !== 1'b1 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL new_key_no_bubble: got v=%b d=%h a=%b e=%b expected 1 08 1 0", out_valid, out_data, out_amb, out_err);
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL key_switch_drained: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        load_key(8'h3C);
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL prefill: got out_valid=%b expected 1", out_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_errs = 8'd0;
        tests_run++;
        if (out_valid !== 1'b0 || key_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b kv=%b ir=%b d=%h expected 0 0 0 00", out_valid, key_valid, in_ready, out_data);
        end
        tests_run++;
        if (err_count !== exp_errs) begin
            tests_failed++;
            $display("FAIL mid_reset_err_count: got %0d expected %0d", err_count, exp_errs);
        end
        load_key(8'h3C);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stale_after_reset[%0d]: got out_valid=%b data=%h expected 0", i, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h99) begin
            tests_failed++;
            $display("FAIL post_reset_decode: got v=%b d=%h expected 1 99", out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_decode_plain();
        test_decode_shift();
        test_backpressure();
        test_key_switch();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xor_shift_decoder.md
Name: xor_shift_decoder

Overview:
- Receive-side inverse of the team's XOR/conditional-shift byte encoder. Encoder rule: enc = (key ^ plain), shifted left by 1 with zero fill when key[7]=1.
- Takes encoded bytes over a valid/ready stream, decodes them against a loaded key, and buffers the results in a small FIFO.
- Emits plaintext bytes with per-byte status flags on a valid/ready output stream.
- Sits between the encoded-byte source and downstream consumers.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of two and at least 2.
- CNT_W, 8, width of the saturating error counter (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- key_load  in  1  single-cycle strobe; capture key_in
- key_in  in  8  decode key
- in_valid  in  1  encoded byte valid
- in_ready  out  1  block can accept an encoded byte
- in_data  in  8  encoded byte
- out_valid  out  1  decoded byte available
- out_ready  in  1  consumer accepts the decoded byte
- out_data  out  8  decoded plaintext
- out_amb  out  1  bit 7 of out_data is unrecoverable; it is forced to 0
- out_err  out  1  format error: key[7]=1 and in_data[0]=1
- key_valid  out  1  a key has been loaded since reset
- err_count  out  CNT_W  saturating format-error count (optional feature only)

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - key register = 0; key_valid = 0; FIFO emptied.
  - in_ready = 0, out_valid = 0, out_data = 0, out_amb = 0, out_err = 0, err_count = 0.
  - Reset mid-operation discards all buffered bytes; no partial output appears afterwards.
- FSM states:
  - NOKEY: after reset; in_ready = 0. A key_load moves to RUN on the next cycle.
  - RUN: in_ready = !fifo_full. Further key_load pulses stay in RUN and update the key.
- Key timing:
  - key_load in cycle N: the key register updates at the edge ending cycle N.
  - An input accepted in cycle N is decoded with the old key. Inputs from cycle N+1 onward use the new key.
  - Bytes already in the FIFO are never re-decoded.
- Input transfer: in_valid && in_ready at a clk edge. Decode is combinational from in_data and the key register; the result is written to the FIFO at that edge.
- Decode, key[7]=0:
  - out_data = in_data ^ key.
  - amb = 0, err = 0.
- Decode, key[7]=1:
  - out_data[6:0] = in_data[7:1] ^ key[6:0].
  - out_data[7] = 0, amb = 1.
  - err = in_data[0]. An errored byte is still buffered, not dropped.
- Output stream:
  - out_data, out_amb and out_err are driven from the FIFO head.
  - out_valid = !fifo_empty.
  - Transfer when out_valid && out_ready; the head pops at that edge.
  - While out_valid=1 and out_ready=0, the output signals hold stable.
- Latency: a byte accepted at edge E into an empty FIFO presents out_valid=1 in the cycle after E. Throughput is 1 byte/cycle.
- Full FIFO: in_ready = 0. A push and a pop in the same cycle is allowed whenever the FIFO is not full before the edge. in_ready does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
- Empty FIFO: out_valid = 0 and out_data holds its last value. It is 0 after reset.
- Pointers: log2(DEPTH)+1 bits with wrap bit. Full when the low bits are equal and the wrap bits differ.
- Simultaneous push and pop at count=1: the new byte becomes head on the next cycle, with no bubble.

Optional Feature:
- Macro XSD_ERR_COUNT_EN.
- Defined:
  - err_count increments by 1 on each accepted input with err=1.
  - It saturates at all-ones.
  - It clears only on reset.
- Undefined: err_count is tied to 0 and the counter register is not built.

Decomposition:
- Package xsd_pkg:
  - state enum (NOKEY, RUN).
  - FIFO entry struct {data[7:0], amb, err}.
  - BYTE_W = 8.
  - decode function: (key, enc) -> entry.
- Sub-module xsd_fifo:
  - Parameterised synchronous FIFO of entries, DEPTH deep.
  - push/pop/full/empty interface.
  - Reset behaviour as above.

Test Plan:
- Reset, no key, in_valid=1 -> in_ready=0 and key_valid=0 indefinitely. Then key_load key_in=0x3C -> key_valid=1 next cycle and in_ready=1.
- Key 0x3C, input 0xA5 -> out_data=0x99, amb=0, err=0, out_valid one cycle after acceptance.
- Key 0x85, input 0x4A -> out_data=0x20, amb=1, err=0. Then input 0x4B -> out_data=0x20, err=1, and err_count=1 when XSD_ERR_COUNT_EN is defined.
- out_ready=0 with DEPTH=4: inputs 0x01..0x05 -> four accepted, in_ready=0 on the fifth. Release out_ready -> bytes drain in order, with the fifth accepted as space frees.
- Keys 0x00 then 0x80: key_load same cycle as input 0x10 under key 0x00 -> output 0x10 (old key). Next input 0x10 -> output 0x08 with amb=1.
- Fill 3 entries, assert rst_n=0 for one edge -> out_valid=0, FIFO empty, key_valid=0. err_count=0 when XSD_ERR_COUNT_EN is defined. No stale bytes appear after the next key_load.
